// File: rtl/mem_access_ctrl.sv
// Load/store bus initiator for the word-wide Common_Memory port.
// Sub-word stores run as read-modify-write; loads return extended data on a one-cycle pulse.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W+1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] Adr,
  output logic [31:0]       MWD,
  output logic              MWR,
  output logic              MOE,
  input  logic [31:0]       MRD
);

  localparam int unsigned CNT_W = 2;
  localparam int unsigned HALF_W = 16;

  typedef enum logic [2:0] {IDLE, RD, RWAIT, WR, RESP, ERR} state_t;

  state_t              state, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, uns_q;
  logic [1:0]          size_q, off_q;
  logic [HALF_W-1:0]   wdata_q;

  logic                req_ready_d, mwr_d, moe_d, rsp_valid_d, rsp_err_d;
  logic [ADDR_W-1:0]   adr_d;
  logic [31:0]         mwd_d, rsp_rdata_d;
  logic                accept_c, bad_c;

  // Pick the addressed lane(s) out of a memory word and extend to 32 bits.
  function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [1:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (size)
      2'd0:    return uns ? {24'd0, b} : {{24{b[7]}}, b};
      2'd1:    return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return w;
    endcase
  endfunction

  // Replace the addressed byte or half of the read-back word with the store data.
  function automatic logic [31:0] merge_word(input logic [31:0] w, input logic [15:0] wd,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] m;
    m = w;
    if (size == 2'd0)  m[{off, 3'b000} +: 8] = wd[7:0];
    else if (off[1])   m[31:16] = wd;
    else               m[15:0]  = wd;
    return m;
  endfunction

  assign accept_c = req_valid && req_ready;
  assign bad_c    = (req_size == 2'd3) ||
                    (req_size == 2'd1 && req_addr[0]) ||
                    (req_size == 2'd2 && req_addr[1:0] != 2'd0);

  // Next state and next value of every registered output.
  always_comb begin
    state_d     = state;
    cnt_d       = cnt_q;
    req_ready_d = 1'b0;
    adr_d       = Adr;
    mwd_d       = MWD;
    mwr_d       = 1'b0;
    moe_d       = 1'b0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = 32'd0;
    rsp_err_d   = 1'b0;
    case (state)
      IDLE: begin
        req_ready_d = 1'b1;
        if (accept_c) begin
          req_ready_d = 1'b0;
          if (bad_c) begin
            state_d     = ERR;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
          end else begin
            adr_d = req_addr[ADDR_W+1:2];
            if (req_we && req_size == 2'd2) begin
              state_d = WR;
              mwr_d   = 1'b1;
              mwd_d   = req_wdata;
            end else begin
              state_d = RD;
              moe_d   = 1'b1;
            end
          end
        end
      end
      RD: begin
        state_d = RWAIT;
        moe_d   = 1'b1;
        cnt_d   = '0;
      end
      RWAIT: begin
        moe_d = 1'b1;
        if (cnt_q == CNT_W'(RD_LAT - 1)) begin
          moe_d = 1'b0;
          if (we_q) begin
            state_d = WR;
            mwr_d   = 1'b1;
            mwd_d   = merge_word(MRD, wdata_q, off_q, size_q);
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = load_ext(MRD, off_q, size_q, uns_q);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WR: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
      end
      RESP, ERR: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
      default: begin
        state_d     = IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      uns_q     <= 1'b0;
      size_q    <= 2'd0;
      off_q     <= 2'd0;
      wdata_q   <= '0;
      req_ready <= 1'b1;
      Adr       <= '0;
      MWD       <= 32'd0;
      MWR       <= 1'b0;
      MOE       <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_d;
      cnt_q     <= cnt_d;
      if (accept_c) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        size_q  <= req_size;
        off_q   <= req_addr[1:0];
        wdata_q <= req_wdata[HALF_W-1:0];
      end
      req_ready <= req_ready_d;
      Adr       <= adr_d;
      MWD       <= mwd_d;
      MWR       <= mwr_d;
      MOE       <= moe_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      rsp_err   <= rsp_err_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl with a behavioural word memory (RD_LAT = 1).
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W = 9;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_we, req_unsigned;
  logic [ADDR_W+1:0] req_addr;
  logic [1:0]        req_size;
  logic [31:0]       req_wdata;
  logic              rsp_valid, rsp_err;
  logic [31:0]       rsp_rdata;
  logic [ADDR_W-1:0] Adr;
  logic [31:0]       MWD, MRD;
  logic              MWR, MOE;

  int errors = 0;
  int checks = 0;

  mem_access_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .Adr(Adr), .MWD(MWD), .MWR(MWR), .MOE(MOE), .MRD(MRD)
  );

  always #5 clk = ~clk;

  // Word memory: one-cycle read latency from the MOE sampling edge.
  logic [31:0] mem [512];
  always @(posedge clk) begin
    if (MWR) mem[Adr] <= MWD;
    if (MOE) MRD <= mem[Adr];
  end

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_mwr;
    int          exp_moe;
    logic [8:0]  exp_adr;
    logic [31:0] exp_mwd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic we, input logic [10:0] addr, input logic [1:0] size,
                              input logic uns, input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic err, input int lat, input int nmwr, input int nmoe,
                              input logic [31:0] mwd);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.exp_rdata = rdata; v.exp_err = err; v.exp_lat = lat; v.exp_mwr = nmwr;
    v.exp_moe = nmoe; v.exp_adr = addr[10:2]; v.exp_mwd = mwd;
    return v;
  endfunction

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%08h expected 0x%08h", name, idx, got, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    req_we = v.we; req_addr = v.addr; req_size = v.size;
    req_unsigned = v.uns; req_wdata = v.wdata; req_valid = 1'b1;
  endtask

  // Issue one request from an idle negedge and observe it to completion.
  task automatic xact(input vec_t v, output logic [31:0] rdata, output logic err,
                      output int lat, output int nmwr, output int nmoe, output int nover,
                      output int nadr, output logic [31:0] mwd_seen, output logic ready_after);
    drive(v);
    nmwr = 0; nmoe = 0; nover = 0; nadr = 0; mwd_seen = 32'd0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    for (int c = 0; c < 20; c++) begin
      if (MWR) begin nmwr++; mwd_seen = MWD; end
      if (MOE) nmoe++;
      if (MWR && MOE) nover++;
      if ((MWR || MOE) && Adr != v.exp_adr) nadr++;
      if (rsp_valid) break;
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
    ready_after = req_ready;
  endtask

  task automatic run_vec(input vec_t v, input int i);
    logic [31:0] rdata, mwd_seen;
    logic        err, ready_after;
    int          lat, nmwr, nmoe, nover, nadr;
    xact(v, rdata, err, lat, nmwr, nmoe, nover, nadr, mwd_seen, ready_after);
    check("latency", i, 32'(lat), 32'(v.exp_lat));
    check("rsp_err", i, 32'(err), 32'(v.exp_err));
    check("rsp_rdata", i, rdata, v.exp_rdata);
    check("mwr_cycles", i, 32'(nmwr), 32'(v.exp_mwr));
    check("moe_cycles", i, 32'(nmoe), 32'(v.exp_moe));
    check("mwr_moe_overlap", i, 32'(nover), 32'd0);
    check("ready_after_rsp", i, 32'(ready_after), 32'd1);
    if (v.exp_mwr + v.exp_moe > 0) check("adr", i, 32'(nadr), 32'd0);
    if (v.exp_mwr > 0) check("mwd", i, mwd_seen, v.exp_mwd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t bb[$];
    vec_t v;
    int   idx, rsp_idx, accepts, rsps, pending;
    logic will_acc;

    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_size = 2'd0;
    req_unsigned = 1'b0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", 0, 32'(req_ready), 32'd1);
    check("rst_adr", 0, 32'(Adr), 32'd0);
    check("rst_mwd", 0, MWD, 32'd0);
    check("rst_mwr_moe", 0, {30'd0, MWR, MOE}, 32'd0);
    check("rst_rsp", 0, {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("rst_rdata", 0, rsp_rdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // we addr size uns wdata | rdata err lat mwr moe mwd
    vecs.push_back(mk(1, 11'd40,  2, 0, 32'h0000_0001, 32'h0, 0, 2, 1, 0, 32'h0000_0001));
    vecs.push_back(mk(0, 11'd40,  2, 0, 32'h0,         32'h0000_0001, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(1, 11'd0,   2, 0, 32'hAABBCCDD,  32'h0, 0, 2, 1, 0, 32'hAABBCCDD));
    vecs.push_back(mk(1, 11'd2,   0, 0, 32'hFFFFFF11,  32'h0, 0, 4, 1, 2, 32'hAA11CCDD));
    vecs.push_back(mk(0, 11'd0,   2, 0, 32'h0,         32'hAA11CCDD, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(1, 11'd0,   2, 0, 32'hAABBCCDD,  32'h0, 0, 2, 1, 0, 32'hAABBCCDD));
    vecs.push_back(mk(0, 11'd3,   0, 0, 32'h0,         32'hFFFFFFAA, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(0, 11'd3,   0, 1, 32'h0,         32'h000000AA, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(0, 11'd0,   1, 0, 32'h0,         32'hFFFFCCDD, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(0, 11'd2,   1, 1, 32'h0,         32'h0000AABB, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(0, 11'd2,   1, 0, 32'h0,         32'hFFFFAABB, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(0, 11'd1,   0, 0, 32'h0,         32'hFFFFFFCC, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(0, 11'd0,   0, 1, 32'h0,         32'h000000DD, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(0, 11'd6,   2, 0, 32'h0,         32'h0, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 11'd1,   1, 0, 32'h0,         32'h0, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 11'd0,   3, 0, 32'h0,         32'h0, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 11'd2,   2, 0, 32'h12345678,  32'h0, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(1, 11'd3,   1, 0, 32'h00005678,  32'h0, 1, 1, 0, 0, 32'h0));
    vecs.push_back(mk(0, 11'd0,   2, 0, 32'h0,         32'hAABBCCDD, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(1, 11'd2,   1, 0, 32'hFFFF1234,  32'h0, 0, 4, 1, 2, 32'h1234CCDD));
    vecs.push_back(mk(0, 11'd0,   2, 0, 32'h0,         32'h1234CCDD, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(1, 11'h7FC, 2, 0, 32'hDEADBEEF,  32'h0, 0, 2, 1, 0, 32'hDEADBEEF));
    vecs.push_back(mk(0, 11'h7FF, 0, 1, 32'h0,         32'h000000DE, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(0, 11'h7FE, 1, 0, 32'h0,         32'hFFFFDEAD, 0, 3, 0, 2, 32'h0));
    vecs.push_back(mk(1, 11'h7FD, 0, 0, 32'h00000077,  32'h0, 0, 4, 1, 2, 32'hDEAD77EF));
    vecs.push_back(mk(0, 11'h7FC, 2, 0, 32'h0,         32'hDEAD77EF, 0, 3, 0, 2, 32'h0));

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Reset during RWAIT of a half store: no write, no response, word unchanged.
    run_vec(mk(1, 11'd0, 2, 0, 32'h55667788, 32'h0, 0, 2, 1, 0, 32'h55667788), 100);
    drive(mk(1, 11'd0, 1, 0, 32'h0000BEEF, 32'h0, 0, 0, 0, 0, 32'h0));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid_in_rd", 101, 32'(MOE), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_ready", 101, 32'(req_ready), 32'd1);
    check("rst_mid_outs", 101, {29'd0, MWR, MOE, rsp_valid}, 32'd0);
    begin
      int nact;
      nact = 0;
      repeat (5) begin
        @(negedge clk);
        if (MWR || rsp_valid) nact++;
      end
      check("rst_mid_quiet", 101, 32'(nact), 32'd0);
    end
    run_vec(mk(0, 11'd0, 2, 0, 32'h0, 32'h55667788, 0, 3, 0, 2, 32'h0), 102);

    // Back-to-back requests with req_valid held high.
    bb.push_back(mk(1, 11'd16, 2, 0, 32'hCAFEF00D, 32'h0, 0, 0, 0, 0, 32'h0));
    bb.push_back(mk(0, 11'd16, 2, 0, 32'h0,        32'hCAFEF00D, 0, 0, 0, 0, 32'h0));
    bb.push_back(mk(0, 11'd16, 3, 0, 32'h0,        32'h0, 1, 0, 0, 0, 32'h0));
    bb.push_back(mk(0, 11'd17, 0, 1, 32'h0,        32'h000000F0, 0, 0, 0, 0, 32'h0));
    bb.push_back(mk(1, 11'd19, 0, 0, 32'h00000099, 32'h0, 0, 0, 0, 0, 32'h0));
    bb.push_back(mk(0, 11'd16, 2, 0, 32'h0,        32'h99FEF00D, 0, 0, 0, 0, 32'h0));
    idx = 0; rsp_idx = 0; accepts = 0; rsps = 0; pending = 0;
    for (int c = 0; c < 100 && (idx < bb.size() || pending > 0); c++) begin
      if (idx < bb.size()) drive(bb[idx]);
      else req_valid = 1'b0;
      will_acc = req_valid && req_ready;
      @(posedge clk);
      @(negedge clk);
      if (will_acc) begin
        accepts++; idx++; pending++;
        check("bb_ready_drop", idx, 32'(req_ready), 32'd0);
      end
      check("bb_mwr_moe", c, 32'(MWR && MOE), 32'd0);
      if (rsp_valid) begin
        rsps++;
        check("bb_one_rsp_per_accept", rsp_idx, 32'(pending), 32'd1);
        if (rsp_idx < bb.size()) begin
          v = bb[rsp_idx];
          check("bb_rsp_err", rsp_idx, 32'(rsp_err), 32'(v.exp_err));
          check("bb_rsp_rdata", rsp_idx, rsp_rdata, v.exp_rdata);
        end
        rsp_idx++;
        pending--;
      end
    end
    req_valid = 1'b0;
    check("bb_accepts", 0, 32'(accepts), 32'(bb.size()));
    check("bb_responses", 0, 32'(rsps), 32'(bb.size()));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
